top_int2_float: RTL and testbench
=================================

TOP_INT2_FLOAT -- requirements
Module: top_int2_float

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit data-memory words.
REQ-002 Parameter EXP_BIAS, default 15, half-precision exponent bias.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; also acts as the start command.
REQ-005 done  output  1  level flag; high = result written to memory.
REQ-006 Operand and result pass only through the internal data memory, instance data_mem1, array my_memory[0:MEM_DEPTH-1] of 8-bit words, hierarchically accessible.
REQ-007 Memory map: word 0 = operand[15:8]; word 1 = operand[7:0]; word 5 = {sign, exp[4:0], mant[9:8]}; word 6 = mant[7:0].

Function
REQ-008 The operand is sign-magnitude: sign = bit 15, magnitude M = bits 14:0 (unsigned, 0..32767).
REQ-009 Result is IEEE-754 half precision: sign, 5-bit biased exponent, 10-bit fraction with an implied leading 1.
REQ-010 M = 0 shall produce exponent 0 and fraction 0, with word 5 bit 7 = sign.
REQ-011 For M != 0, with p = index of the most significant 1 in M: exponent = p + EXP_BIAS; significand = M normalized to 11 bits, hidden bit included.
REQ-012 For p <= 10: exact conversion, fraction = bits below p left-aligned and zero-padded.
REQ-013 For p >= 11: round to nearest even. Guard = bit p-11; sticky = OR of bits below the guard; lsb = bit p-10. Increment the significand when guard AND (lsb OR sticky).
REQ-014 If rounding carries out of the 11-bit significand: exponent +1 and fraction = 0. Maximum reachable exponent is 30, so no overflow or infinity case exists.
REQ-015 FSM states, one cycle each: IDLE (held while reset) -> LOAD (read words 0,1) -> NORM (priority-encode p, shift) -> ROUND -> WR_HI (write word 5) -> WR_LO (write word 6) -> DONE.
REQ-016 DONE is terminal until the next reset.
REQ-017 done shall be 0 in every state except DONE and shall stay 1 while in DONE.
REQ-018 done shall rise no later than the 6th rising edge after the first edge with reset low.
REQ-019 Word 5 bit 7 shall be written with operand bit 15, so the final word 5 is complete regardless of prior contents.
REQ-020 Memory: asynchronous read, synchronous write, one write port driven by the FSM. No other words are modified.
REQ-021 Reset asserted mid-conversion shall abort: return to IDLE and drop done on the next edge. A partially written word 5/6 is tolerated and overwritten on the next run.

Reset
REQ-022 On any edge with reset high: state = IDLE, done = 0, internal operand/exponent/significand registers = 0.
REQ-023 Reset shall NOT clear the data memory; the operand is loaded into memory while reset is high.
REQ-024 Conversion starts on the first edge after reset falls and reads words 0/1 at that time.

Structure
REQ-025 Shared package int2flt_pkg holds the FSM state enum, EXP_BIAS, and the word addresses 0, 1, 5, 6.
REQ-026 One sub-module, data_mem (instance data_mem1), holding the my_memory array. Normalization and rounding stay in the top-level FSM datapath.

Verification
REQ-027 Operand 0x0000 -> word5/6 = 0x00/0x00, done high.
REQ-028 Operand 0x0001 -> half 0x3C00.
REQ-029 Operand 0x0003 -> half 0x4200.
REQ-030 Operand 0x782F (30767) -> half 0x7783, rounded up.
REQ-031 Operand 0x7FFF -> half 0x7800 (rounding carry, exponent 30). Operand 0x1FFF -> half 0x7000.
REQ-032 Operand 0x4008 (tie, even lsb) -> half 0x7400, not rounded. Operand 0x8003 -> half 0xC200 (sign passed through).
REQ-033 Bench shall also cover 20+ random operands shifted right by random 0..15 against a reference model, plus a reset pulse mid-conversion followed by a clean rerun.

Source files
------------

// File: rtl/int2flt_pkg.sv
// Shared definitions for the integer-to-half-float converter: FSM states,
// exponent bias and the data-memory word map.
package int2flt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NORM,
    S_ROUND,
    S_WR_HI,
    S_WR_LO,
    S_DONE
  } state_t;

  localparam int EXP_BIAS = 15;

  localparam int ADDR_OP_HI  = 0;
  localparam int ADDR_OP_LO  = 1;
  localparam int ADDR_RES_HI = 5;
  localparam int ADDR_RES_LO = 6;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: two asynchronous read ports, one synchronous write port.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] my_memory [0:DEPTH-1];

  // NOTE: the array has no reset on purpose; the operand is preloaded while
  // the converter is held in reset and must survive it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      my_memory[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = my_memory[raddr_a_i];
  assign rdata_b_o = my_memory[raddr_b_i];

endmodule

// File: rtl/top_int2_float.sv
// Converts a 16-bit sign-magnitude integer held in data memory into an IEEE-754
// half-precision value (round to nearest even) and writes it back to memory.
module top_int2_float
  import int2flt_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int EXP_BIAS  = int2flt_pkg::EXP_BIAS
) (
  input  logic clk,
  input  logic reset,
  output logic done
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t state_q, state_d;

  logic [15:0]   operand_q;
  logic [4:0]    exp_q;
  logic [14:0]   norm_q;
  logic [15:0]   result_q;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rdata_hi;
  logic [7:0]    rdata_lo;

  logic [3:0]    msb_pos;
  logic [14:0]   norm_shift;
  logic          guard, sticky, lsb, round_up;
  logic [11:0]   sig_rnd;
  logic          is_zero;
  logic [4:0]    exp_rnd;
  logic [9:0]    frac_rnd;

  data_mem #(
    .DEPTH(MEM_DEPTH),
    .AW   (AW)
  ) data_mem1 (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .raddr_a_i(AW'(ADDR_OP_HI)),
    .rdata_a_o(rdata_hi),
    .raddr_b_i(AW'(ADDR_OP_LO)),
    .rdata_b_o(rdata_lo)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_WR_HI;
      S_WR_HI: state_d = S_WR_LO;
      S_WR_LO: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can
  // infer a latch.
  always_comb begin
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      S_WR_HI: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(ADDR_RES_HI);
        mem_wdata = result_q[15:8];
      end
      S_WR_LO: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(ADDR_RES_LO);
        mem_wdata = result_q[7:0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < 15; i++) begin
      if (operand_q[i]) msb_pos = 4'(i);
    end
    norm_shift = operand_q[14:0] << (4'd14 - msb_pos);
  end

  // norm_q holds the magnitude with its leading one at bit 14: bits 14:4 are
  // the 11-bit significand, bit 3 the guard, bits 2:0 the sticky bits.
  always_comb begin
    guard    = norm_q[3];
    sticky   = |norm_q[2:0];
    lsb      = norm_q[4];
    round_up = guard & (lsb | sticky);
    sig_rnd  = {1'b0, norm_q[14:4]} + {11'd0, round_up};
    is_zero  = ~(sig_rnd[11] | sig_rnd[10]);
    exp_rnd  = is_zero ? 5'd0 : (exp_q + {4'd0, sig_rnd[11]});
    frac_rnd = sig_rnd[11] ? 10'd0 : sig_rnd[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operand_q <= '0;
      exp_q     <= '0;
      norm_q    <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_LOAD:  operand_q <= {rdata_hi, rdata_lo};
        S_NORM: begin
          exp_q  <= 5'(msb_pos) + 5'(EXP_BIAS);
          norm_q <= norm_shift;
        end
        S_ROUND: result_q <= {operand_q[15], exp_rnd, frac_rnd};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_int2_float.sv
// Directed and random checks of the integer-to-half converter through its data memory.
module tb_top_int2_float;

  logic clk;
  logic reset;
  logic done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] op;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [13];

  top_int2_float #(
    .MEM_DEPTH(256),
    .EXP_BIAS (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: integer division style rounding on the magnitude.
  function automatic logic [15:0] ref_half(input logic [15:0] op);
    int m, p, s, q, rem, half, e;
    m = int'(op[14:0]);
    if (m == 0) return {op[15], 15'd0};
    p = 0;
    for (int i = 0; i < 15; i++) if (m >= (1 << i)) p = i;
    e = p + 15;
    if (p <= 10) begin
      q = m << (10 - p);
    end else begin
      s    = p - 10;
      q    = m >> s;
      rem  = m - (q << s);
      half = 1 << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        e = e + 1;
      end
    end
    return {op[15], 5'(e), 10'(q & 1023)};
  endfunction

  task automatic run_conv(input logic [15:0] op, output logic [15:0] res);
    int edges;
    @(negedge clk);
    reset = 1'b1;
    dut.data_mem1.my_memory[0] = op[15:8];
    dut.data_mem1.my_memory[1] = op[7:0];
    dut.data_mem1.my_memory[2] = 8'hC3;
    dut.data_mem1.my_memory[5] = 8'hA5;
    dut.data_mem1.my_memory[6] = 8'h5A;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check($sformatf("latency_le_6 op=%04h edges=%0d", op, edges), 32'(edges <= 6), 32'd1);
    res = {dut.data_mem1.my_memory[5], dut.data_mem1.my_memory[6]};
    @(posedge clk);
    #1;
    check($sformatf("done_hold op=%04h", op), 32'(done), 32'd1);
    check($sformatf("word2_untouched op=%04h", op), 32'(dut.data_mem1.my_memory[2]), 32'h00C3);
  endtask

  initial begin
    logic [15:0] res;
    logic [31:0] r;
    logic [15:0] op;
    int          sh;

    vecs[0]  = '{16'h0000, 16'h0000};
    vecs[1]  = '{16'h0001, 16'h3C00};
    vecs[2]  = '{16'h0003, 16'h4200};
    vecs[3]  = '{16'h782F, 16'h7783};
    vecs[4]  = '{16'h7FFF, 16'h7800};
    vecs[5]  = '{16'h1FFF, 16'h7000};
    vecs[6]  = '{16'h4008, 16'h7400};
    vecs[7]  = '{16'h8003, 16'hC200};
    vecs[8]  = '{16'h8000, 16'h8000};
    vecs[9]  = '{16'h0400, 16'h6400};
    vecs[10] = '{16'h07FF, 16'h67FF};
    vecs[11] = '{16'h0801, 16'h6800};
    vecs[12] = '{16'h0803, 16'h6802};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done_low", 32'(done), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_conv(vecs[i].op, res);
      check($sformatf("vec%0d op=%04h", i, vecs[i].op), 32'(res), 32'(vecs[i].res));
    end

    for (int i = 0; i < 24; i++) begin
      r  = $urandom();
      sh = $urandom_range(0, 15);
      op = {r[15], r[14:0] >> sh};
      run_conv(op, res);
      check($sformatf("rand%0d op=%04h", i, op), 32'(res), 32'(ref_half(op)));
    end

    // Reset after completion drops done on the next edge.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_drops_done", 32'(done), 32'd0);

    // Abort mid-conversion, then a clean rerun with a different operand.
    @(negedge clk);
    dut.data_mem1.my_memory[0] = 8'h7F;
    dut.data_mem1.my_memory[1] = 8'hFF;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_mid_done_low", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_reset_done_low", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_held_done_low", 32'(done), 32'd0);
    run_conv(16'h0803, res);
    check("rerun_after_abort", 32'(res), 32'h6802);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
